preamble_aligner: RTL and testbench

PREAMBLE_ALIGNER -- requirements
Module: preamble_aligner

---
 rtl/preamble_pkg.sv | 20 ++
 rtl/preamble_lane_compare.sv | 110 +++++++++++
 rtl/preamble_aligner.sv | 219 +++++++++++++++++++++
 tb/tb_preamble_aligner.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preamble_pkg.sv
// -----------------------------------------------------------------------------
// preamble_pkg
// Shared definitions for the preamble aligner: default geometry of the ADC
// beat and the encoding of the aligner FSM state (also visible on the
// 'state' output port).
// -----------------------------------------------------------------------------
package preamble_pkg;

    localparam int DEF_LANES    = 16;  // samples per beat
    localparam int DEF_SAMPLE_W = 16;  // bits per unsigned sample
    localparam int DEF_CNT_W    = 16;  // cycle-length / counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOCK = 2'd2,
        ST_PASS = 2'd3
    } state_e;

endpackage

// File: rtl/preamble_lane_compare.sv
// -----------------------------------------------------------------------------
// preamble_lane_compare
// Stage 1 of the aligner. Slices every lane of a valid beat against the
// threshold, keeps the current and previous valid beat (bits and data), and
// presents, for every lane shift k, whether the aligned slice vector equals
// the pattern. The aligned data word for the selected shift is also output.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        synchronous flush of the stage (restart of a hunt)
//   s_tdata_i      input beat, lane i at [i*SAMPLE_W +: SAMPLE_W]
//   s_tvalid_i     input beat qualifier
//   threshold_i    slicing level, sample >= threshold gives bit 1
//   pattern_i      expected slice vector of one preamble beat
//   shift_i        shift used to build word_o
//   beat_valid_o   a new beat is held in the stage this cycle
//   match_o        bit k set when the shift-k aligned bits equal pattern_i
//   word_o         aligned data word for shift_i
// -----------------------------------------------------------------------------
module preamble_lane_compare
    import preamble_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic [LANES*SAMPLE_W-1:0]  s_tdata_i,
    input  logic                       s_tvalid_i,
    input  logic [SAMPLE_W-1:0]        threshold_i,
    input  logic [LANES-1:0]           pattern_i,
    input  logic [$clog2(LANES)-1:0]   shift_i,
    output logic                       beat_valid_o,
    output logic [LANES-1:0]           match_o,
    output logic [LANES*SAMPLE_W-1:0]  word_o
);

    localparam int DATA_W  = LANES * SAMPLE_W;
    localparam int SHIFT_W = $clog2(LANES);

    logic [LANES-1:0]    slice;
    logic [LANES-1:0]    bits_q;
    logic [LANES-1:0]    bits_prev_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_prev_q;
    logic                valid_q;
    logic [2*LANES-1:0]  bits_win;
    logic [2*DATA_W-1:0] data_win;

    // NOTE: every signal driven here gets a default before any conditional
    // or loop assignment, so the block stays purely combinational (no latch).
    always_comb begin
        slice = '0;
        for (int i = 0; i < LANES; i++) begin
            slice[i] = (s_tdata_i[i*SAMPLE_W +: SAMPLE_W] >= threshold_i);
        end
    end

    // NOTE: the wide data registers are reset along with the control bits so
    // that nothing downstream ever sees a stale or undefined word after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q      <= '0;
            bits_prev_q <= '0;
            data_q      <= '0;
            data_prev_q <= '0;
            valid_q     <= 1'b0;
        end else if (clear_i) begin
            // A restart drops the in-flight beat and forgets history, so a
            // new hunt never pairs with a beat from the previous frame.
            bits_q      <= '0;
            bits_prev_q <= '0;
            data_q      <= '0;
            data_prev_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge value, so bits_prev_q really receives the old bits_q.
            valid_q <= s_tvalid_i;
            if (s_tvalid_i) begin
                bits_prev_q <= bits_q;
                bits_q      <= slice;
                data_prev_q <= data_q;
                data_q      <= s_tdata_i;
            end
        end
    end

    // Previous beat in the low half, current beat in the high half: a window
    // starting at lane k (k >= 1) is prev[k..LANES-1] followed by cur[0..k-1].
    // Shift 0 uses the current beat alone instead of the whole previous beat.
    assign bits_win = {bits_q, bits_prev_q};
    assign data_win = {data_q, data_prev_q};

    always_comb begin
        match_o    = '0;
        word_o     = data_q;
        match_o[0] = (bits_q == pattern_i);
        for (int k = 1; k < LANES; k++) begin
            match_o[k] = (bits_win[k +: LANES] == pattern_i);
            if (shift_i == SHIFT_W'(k)) begin
                word_o = data_win[k*SAMPLE_W +: DATA_W];
            end
        end
    end

    assign beat_valid_o = valid_q;

endmodule

// File: rtl/preamble_aligner.sv
// -----------------------------------------------------------------------------
// preamble_aligner
// Hunts for a repeating preamble in a multi-lane ADC stream, locks onto the
// lane shift at which it appears, then emits the following payload beats
// re-aligned to that shift. Beat-to-output latency is two clocks.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle restart; latches all configuration
//   s_tdata, s_tvalid       input beats (no backpressure)
//   threshold, pattern      slicing level and expected preamble slice vector
//   preamble_cycles         matching beats needed for lock (0 = disabled)
//   payload_cycles          beats emitted after lock (0 = unbounded)
//   m_tdata/m_tvalid/m_tlast aligned payload stream
//   locked, lock_shift      lock status and the locked lane shift
//   err_cnt                 saturating count of non-matching hunt beats
//   state                   FSM state (IDLE/HUNT/LOCK/PASS)
// -----------------------------------------------------------------------------
module preamble_aligner
    import preamble_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LANES*SAMPLE_W-1:0]  s_tdata,
    input  logic                       s_tvalid,
    input  logic [SAMPLE_W-1:0]        threshold,
    input  logic [LANES-1:0]           pattern,
    input  logic [CNT_W-1:0]           preamble_cycles,
    input  logic [CNT_W-1:0]           payload_cycles,
    output logic [LANES*SAMPLE_W-1:0]  m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    output logic                       locked,
    output logic [$clog2(LANES)-1:0]   lock_shift,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [1:0]                 state
);

    localparam int DATA_W  = LANES * SAMPLE_W;
    localparam int SHIFT_W = $clog2(LANES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    run_q, run_d;
    logic [SHIFT_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic                locked_q, locked_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;

    // Configuration captured on start only.
    logic [SAMPLE_W-1:0] thr_q;
    logic [LANES-1:0]    pat_q;
    logic [CNT_W-1:0]    pre_q;
    logic [CNT_W-1:0]    pay_q;

    logic                beat_v;
    logic [LANES-1:0]    match;
    logic [DATA_W-1:0]   word;
    logic                any_match;
    logic [SHIFT_W-1:0]  best_k;
    logic [CNT_W-1:0]    run_next;
    logic [CNT_W-1:0]    cnt_inc;
    logic                emit;

    preamble_lane_compare #(
        .LANES    (LANES),
        .SAMPLE_W (SAMPLE_W)
    ) u_compare (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start),
        .s_tdata_i    (s_tdata),
        .s_tvalid_i   (s_tvalid),
        .threshold_i  (thr_q),
        .pattern_i    (pat_q),
        .shift_i      (shift_q),
        .beat_valid_o (beat_v),
        .match_o      (match),
        .word_o       (word)
    );

    // Lowest matching shift wins: scan downwards so the last hit is the lowest.
    always_comb begin
        best_k    = '0;
        any_match = |match;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (match[k]) begin
                best_k = SHIFT_W'(k);
            end
        end
    end

    // A run only continues while the same shift keeps matching.
    assign run_next = (run_q != '0 && best_k == cand_q) ? sat_inc(run_q) : CNT_W'(1);
    assign cnt_inc  = sat_inc(cnt_q);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        locked_d = locked_q;
        shift_d  = shift_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        emit     = 1'b0;

        if (start) begin
            // Restart wins over any beat in flight; a truncated frame gets no
            // m_tlast.
            state_d  = (preamble_cycles != '0) ? ST_HUNT : ST_IDLE;
            run_d    = '0;
            cand_d   = '0;
            cnt_d    = '0;
            err_d    = '0;
            locked_d = 1'b0;
        end else if (beat_v) begin
            case (state_q)
                ST_HUNT: begin
                    if (any_match) begin
                        cand_d = best_k;
                        run_d  = run_next;
                        if (run_next == pre_q) begin
                            state_d  = ST_LOCK;
                            locked_d = 1'b1;
                            shift_d  = best_k;
                            run_d    = '0;
                        end
                    end else begin
                        run_d = '0;
                        err_d = sat_inc(err_q);
                    end
                end
                ST_LOCK: begin
                    // First beat that stops matching is payload word 0.
                    if (!match[shift_q]) begin
                        state_d = ST_PASS;
                        emit    = 1'b1;
                    end
                end
                ST_PASS: emit = 1'b1;
                default: ;
            endcase

            // cnt_q is zero on entry to LOCK, so the first word counts as 1.
            if (emit) begin
                tvalid_d = 1'b1;
                tdata_d  = word;
                cnt_d    = cnt_inc;
                if (pay_q != '0 && cnt_inc == pay_q) begin
                    tlast_d  = 1'b1;
                    state_d  = ST_HUNT;
                    locked_d = 1'b0;
                    cnt_d    = '0;
                    run_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            run_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            thr_q    <= '0;
            pat_q    <= '0;
            pre_q    <= '0;
            pay_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            if (start) begin
                thr_q <= threshold;
                pat_q <= pattern;
                pre_q <= preamble_cycles;
                pay_q <= payload_cycles;
            end
        end
    end

    assign m_tdata    = tdata_q;
    assign m_tvalid   = tvalid_q;
    assign m_tlast    = tlast_q;
    assign locked     = locked_q;
    assign lock_shift = shift_q;
    assign err_cnt    = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_preamble_aligner.sv
// -----------------------------------------------------------------------------
// tb_preamble_aligner
// Directed bench for preamble_aligner (LANES=16, SAMPLE_W=16, CNT_W=16,
// threshold 0x8000, pattern 0x00FF). Inputs are driven 1 time unit after the
// rising edge; an observer on the falling edge records every output word with
// the cycle it appeared in, so latency and gap pattern can be compared with
// the cycles in which the beats were driven.
// -----------------------------------------------------------------------------
module tb_preamble_aligner;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] s_tdata;
    logic         s_tvalid;
    logic [15:0]  threshold;
    logic [15:0]  pattern;
    logic [15:0]  preamble_cycles;
    logic [15:0]  payload_cycles;
    logic [255:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         locked;
    logic [3:0]   lock_shift;
    logic [15:0]  err_cnt;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           in_cyc[$];
    logic [255:0] out_data[$];
    logic         out_last[$];
    int           out_cyc[$];

    preamble_aligner #(
        .LANES    (16),
        .SAMPLE_W (16),
        .CNT_W    (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .threshold       (threshold),
        .pattern         (pattern),
        .preamble_cycles (preamble_cycles),
        .payload_cycles  (payload_cycles),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tlast         (m_tlast),
        .locked          (locked),
        .lock_shift      (lock_shift),
        .err_cnt         (err_cnt),
        .state           (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid) begin
            out_data.push_back(m_tdata);
            out_last.push_back(m_tlast);
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by time limit, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lanes 0-7 = lo, lanes 8-15 = hi.
    function automatic logic [255:0] fill(input logic [15:0] lo, input logic [15:0] hi);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = (i < 8) ? lo : hi;
        return v;
    endfunction

    // Payload word r: lane i = r*256 + i (always below the threshold).
    function automatic logic [255:0] ramp(input int r);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(r * 256 + i);
        return v;
    endfunction

    // Stream delayed by 5 lanes: 5 filler lanes, 4 preamble beats, ramp 1..3.
    function automatic logic [15:0] off_sample(input int s);
        if (s < 5)        return 16'h1000;
        else if (s < 69)  return (((s - 5) % 16) < 8) ? 16'hC000 : 16'h1000;
        else if (s < 117) return 16'((((s - 69) / 16) + 1) * 256 + ((s - 69) % 16));
        else              return 16'h1000;
    endfunction

    function automatic logic [255:0] off_beat(input int n);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = off_sample(16 * n + i);
        return v;
    endfunction

    task automatic beat(input logic [255:0] d);
        s_tdata  = d;
        s_tvalid = 1'b1;
        in_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        in_cyc.delete();
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
    endtask

    task automatic do_start(input logic [15:0] pc, input logic [15:0] pl);
        preamble_cycles = pc;
        payload_cycles  = pl;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear_log();
    endtask

    initial begin
        logic [255:0] pre_b;
        logic [255:0] low_b;
        int           nlast;

        pre_b = fill(16'hC000, 16'h1000);
        low_b = fill(16'h1000, 16'h1000);

        rst_n           = 1'b0;
        start           = 1'b0;
        s_tdata         = '0;
        s_tvalid        = 1'b0;
        threshold       = 16'h8000;
        pattern         = 16'h00FF;
        preamble_cycles = '0;
        payload_cycles  = '0;
        idle(3);

        // Reset state
        check("rst state",      256'(state),      256'(0));
        check("rst m_tvalid",   256'(m_tvalid),   256'(0));
        check("rst m_tlast",    256'(m_tlast),    256'(0));
        check("rst locked",     256'(locked),     256'(0));
        check("rst lock_shift", 256'(lock_shift), 256'(0));
        check("rst err_cnt",    256'(err_cnt),    256'(0));
        check("rst m_tdata",    m_tdata,          256'(0));
        rst_n = 1'b1;
        idle(1);

        // A: aligned preamble, 3-word payload
        do_start(16'd4, 16'd3);
        check("A state hunt", 256'(state), 256'(1));
        repeat (4) beat(pre_b);
        beat(ramp(1));
        check("A locked",     256'(locked),     256'(1));
        check("A lock_shift", 256'(lock_shift), 256'(0));
        check("A state lock", 256'(state),      256'(2));
        beat(ramp(2));
        check("A state pass", 256'(state), 256'(3));
        beat(ramp(3));
        idle(3);
        check("A word count", 256'(out_data.size()), 256'(3));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("A word%0d", i), out_data[i], ramp(i + 1));
            check($sformatf("A last%0d", i), 256'(out_last[i]), 256'(i == 2));
            check($sformatf("A lat%0d", i), 256'(out_cyc[i]), 256'(in_cyc[4 + i] + 2));
        end
        check("A state end",  256'(state),   256'(1));
        check("A unlocked",   256'(locked),  256'(0));
        check("A err_cnt",    256'(err_cnt), 256'(0));

        // B: preamble offset by 5 lanes across beat boundaries
        do_start(16'd4, 16'd3);
        for (int n = 0; n < 8; n++) begin
            beat(off_beat(n));
            if (n == 5) begin
                check("B locked",     256'(locked),     256'(1));
                check("B lock_shift", 256'(lock_shift), 256'(5));
            end
        end
        idle(3);
        check("B word count", 256'(out_data.size()), 256'(3));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("B word%0d", i), out_data[i], ramp(i + 1));
            check($sformatf("B last%0d", i), 256'(out_last[i]), 256'(i == 2));
        end
        check("B err_cnt",   256'(err_cnt), 256'(1));
        check("B state end", 256'(state),   256'(1));

        // C: one corrupted beat after two matches restarts the run
        do_start(16'd4, 16'd2);
        beat(pre_b);
        beat(pre_b);
        beat(low_b);
        beat(pre_b);
        check("C err_cnt",    256'(err_cnt), 256'(1));
        check("C state hunt", 256'(state),   256'(1));
        beat(pre_b);
        beat(pre_b);
        beat(pre_b);
        check("C not yet locked", 256'(locked), 256'(0));
        beat(ramp(1));
        check("C locked",     256'(locked),     256'(1));
        check("C lock_shift", 256'(lock_shift), 256'(0));
        beat(ramp(2));
        idle(3);
        check("C word count", 256'(out_data.size()), 256'(2));
        check("C word0", out_data[0], ramp(1));
        check("C word1", out_data[1], ramp(2));
        check("C last1", 256'(out_last[1]), 256'(1));
        check("C err_end", 256'(err_cnt), 256'(1));

        // D: s_tvalid toggling; configuration changed after start is ignored
        do_start(16'd2, 16'd3);
        preamble_cycles = 16'd7;
        payload_cycles  = 16'd1;
        pattern         = 16'hFFFF;
        threshold       = 16'h0000;
        beat(pre_b);   idle(1);
        beat(pre_b);   idle(1);
        beat(ramp(1)); idle(1);
        beat(ramp(2)); idle(1);
        beat(ramp(3));
        idle(3);
        check("D word count", 256'(out_data.size()), 256'(3));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("D word%0d", i), out_data[i], ramp(i + 1));
            check($sformatf("D last%0d", i), 256'(out_last[i]), 256'(i == 2));
            check($sformatf("D lat%0d", i), 256'(out_cyc[i]), 256'(in_cyc[2 + i] + 2));
        end
        check("D err_cnt", 256'(err_cnt), 256'(0));
        pattern   = 16'h00FF;
        threshold = 16'h8000;

        // E: start in PASS after two of eight words, with a same-cycle beat
        do_start(16'd2, 16'd8);
        beat(low_b);
        beat(pre_b);
        beat(pre_b);
        beat(ramp(1));
        check("E err before", 256'(err_cnt), 256'(1));
        beat(ramp(2));
        beat(ramp(3));
        check("E m_tvalid busy", 256'(m_tvalid), 256'(1));
        start           = 1'b1;
        preamble_cycles = 16'd2;
        s_tdata         = ramp(4);
        s_tvalid        = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        s_tvalid = 1'b0;
        check("E m_tvalid", 256'(m_tvalid), 256'(0));
        check("E m_tlast",  256'(m_tlast),  256'(0));
        check("E state",    256'(state),    256'(1));
        check("E err_cnt",  256'(err_cnt),  256'(0));
        check("E locked",   256'(locked),   256'(0));
        idle(3);
        nlast = 0;
        foreach (out_last[i]) nlast += int'(out_last[i]);
        check("E word count", 256'(out_data.size()), 256'(2));
        check("E no tlast",   256'(nlast),           256'(0));

        // F: asynchronous reset in PASS, then disabled configuration
        do_start(16'd2, 16'd0);
        beat(low_b);
        beat(pre_b);
        beat(pre_b);
        beat(ramp(1));
        beat(ramp(2));
        beat(ramp(3));
        check("F m_tvalid busy", 256'(m_tvalid), 256'(1));
        check("F err before",    256'(err_cnt),  256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("F rst m_tvalid", 256'(m_tvalid), 256'(0));
        check("F rst m_tdata",  m_tdata,        256'(0));
        check("F rst m_tlast",  256'(m_tlast),  256'(0));
        check("F rst locked",   256'(locked),   256'(0));
        check("F rst state",    256'(state),    256'(0));
        check("F rst err_cnt",  256'(err_cnt),  256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        beat(pre_b);
        beat(pre_b);
        idle(3);
        check("F no start state", 256'(state),           256'(0));
        check("F no start words", 256'(out_data.size()), 256'(0));
        do_start(16'd0, 16'd3);
        check("F pc0 state", 256'(state), 256'(0));
        beat(pre_b);
        beat(pre_b);
        beat(ramp(1));
        beat(ramp(2));
        idle(3);
        check("F pc0 words",  256'(out_data.size()), 256'(0));
        check("F pc0 idle",   256'(state),           256'(0));
        check("F pc0 locked", 256'(locked),          256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
